// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Shared types and byte constants for the UART bootloader.
//                Holds the frame-parser state encoding and the sync/command
//                byte values.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // Frame parser states. One byte counter is shared by the multi-byte fields.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_HALT  = 8'hFE;
    localparam logic [7:0] CMD_RUN   = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_8n1
//  Description : 8N1 UART receiver, LSB first. rx is resynchronised through
//                two flops. Data bits are sampled at mid-bit; valid (good
//                stop bit) or frame_err (bad stop bit) pulses for one cycle
//                at mid-stop-bit.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                rx             - asynchronous serial input, idle high
//                data[7:0]      - last received byte
//                valid          - one-cycle pulse, byte in data is good
//                frame_err      - one-cycle pulse, stop bit was low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1 #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int c_bit_cyc  = CLK_FREQ / BAUD_RATE;
    localparam int c_half_cyc = c_bit_cyc / 2;
    localparam int c_cnt_w    = (c_bit_cyc > 1) ? $clog2(c_bit_cyc) : 1;
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_bit_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_cyc - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic               r_ferr;
    logic               w_tick;

    // The start phase only waits half a bit so later samples land mid-bit.
    always_comb begin
        w_tick       = (r_state == RX_START) ? (r_cnt == c_half_last) : (r_cnt == c_bit_last);
        w_state_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_prev && !r_sync2) w_state_next = RX_START;
            // A start bit that is high again at mid-bit was a glitch.
            RX_START: if (w_tick) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_next = RX_STOP;
            RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
            default:  w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_next;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if ((r_state == RX_IDLE) || w_tick) r_cnt <= '0;
            else                                r_cnt <= r_cnt + 1'b1;
            if (r_state == RX_IDLE) r_bit <= '0;
            if ((r_state == RX_DATA) && w_tick) begin
                r_shift <= {r_sync2, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if ((r_state == RX_STOP) && w_tick) begin
                if (r_sync2) r_valid <= 1'b1;
                else         r_ferr  <= 1'b1;
            end
        end
    end

    assign data      = r_shift;
    assign valid     = r_valid;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : UART bootloader. Parses A5-synced, XOR-checksummed frames
//                and issues word writes to one of N_TARGETS memories; holds
//                the CPU in reset while loading; run/halt commands.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rx                  - asynchronous serial input
//                prog_addr/prog_data - byte address / data of current write
//                prog_we             - one-hot, one-cycle write strobe
//                cpu_hold            - 1 holds the CPU in reset
//                busy                - frame in progress
//                err_csum/frame/cmd  - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int N_TARGETS   = 2,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [ADDR_W-1:0]    prog_addr,
    output logic [DATA_W-1:0]    prog_data,
    output logic [N_TARGETS-1:0] prog_we,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 err_csum,
    output logic                 err_frame,
    output logic                 err_cmd
);
    import uart_loader_pkg::*;

    localparam int c_bpw    = DATA_W / 8;
    localparam int c_abytes = ADDR_W / 8;
    localparam int c_tmr_w  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]         c_n_tgt    = 9'(N_TARGETS);
    localparam logic [15:0]        c_abyte_lst = 16'(c_abytes - 1);
    localparam logic [15:0]        c_bpw_lst   = 16'(c_bpw - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_lst   = c_tmr_w'(TIMEOUT_CYC - 1);

    logic [7:0]          w_rx_data;
    logic                w_rx_valid;
    logic                w_rx_ferr;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_cmd;
    logic [7:0]          r_csum;
    logic [15:0]         r_cnt;
    logic [15:0]         r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_word;
    logic [c_tmr_w-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_prog_addr;
    logic [DATA_W-1:0]   r_prog_data;
    logic [N_TARGETS-1:0] r_prog_we;
    logic                r_hold;
    logic                r_err_csum;
    logic                r_err_frame;
    logic                r_err_cmd;

    logic                w_timeout;
    logic                w_cmd_write;
    logic                w_cmd_ctrl;
    logic                w_word_done;
    logic [15:0]         w_len_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [DATA_W-1:0]   w_word_next;

    uart_rx_8n1 #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (w_rx_data),
        .valid     (w_rx_valid),
        .frame_err (w_rx_ferr)
    );

    // Little-endian assembly: each new byte enters at the top and shifts down,
    // so the first byte received ends up in the least significant position.
    assign w_addr_next = (r_addr >> 8) | (ADDR_W'(w_rx_data) << (ADDR_W - 8));
    assign w_word_next = (r_word >> 8) | (DATA_W'(w_rx_data) << (DATA_W - 8));
    assign w_len_next  = {w_rx_data, r_len[15:8]};
    assign w_cmd_write = ({1'b0, w_rx_data} < c_n_tgt);
    assign w_cmd_ctrl  = (w_rx_data == CMD_HALT) || (w_rx_data == CMD_RUN);
    // A byte arriving in the same cycle as the timeout wins.
    assign w_timeout   = (r_state != ST_IDLE) && !w_rx_valid && (r_timer == c_tmr_lst);

    always_comb begin
        w_state_next = r_state;
        w_word_done  = 1'b0;
        if (w_rx_ferr || w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_rx_valid) begin
            case (r_state)
                ST_IDLE: if (w_rx_data == SYNC_BYTE) w_state_next = ST_CMD;
                ST_CMD: begin
                    if (w_cmd_write)     w_state_next = ST_ADDR;
                    else if (w_cmd_ctrl) w_state_next = ST_CSUM;
                    else                 w_state_next = ST_IDLE;
                end
                ST_ADDR: if (r_cnt == c_abyte_lst) w_state_next = ST_LEN;
                ST_LEN: begin
                    if (r_cnt == 16'd1)
                        w_state_next = (w_len_next == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    if (r_cnt == c_bpw_lst) begin
                        w_word_done = 1'b1;
                        if (r_len == 16'd1) w_state_next = ST_CSUM;
                    end
                end
                ST_CSUM: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd <= '0;
            r_csum <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_addr <= '0;
            r_word <= '0;
            r_timer <= '0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_we <= '0;
            r_hold <= 1'b0;
            r_err_csum <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_cmd <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_prog_we <= '0;
            if ((r_state == ST_IDLE) || w_rx_valid || w_timeout) r_timer <= '0;
            else                                                  r_timer <= r_timer + 1'b1;
            if (w_rx_ferr || w_timeout) r_err_frame <= 1'b1;
            if (w_rx_valid) begin
                // The counter restarts on every field change and every word.
                if ((w_state_next != r_state) || w_word_done) r_cnt <= '0;
                else                                          r_cnt <= r_cnt + 16'd1;
                if ((r_state != ST_IDLE) && (r_state != ST_CSUM)) r_csum <= r_csum ^ w_rx_data;
                case (r_state)
                    ST_IDLE: r_csum <= '0;
                    ST_CMD: begin
                        r_cmd <= w_rx_data;
                        if (w_cmd_write)      r_hold <= 1'b1;
                        else if (!w_cmd_ctrl) r_err_cmd <= 1'b1;
                    end
                    ST_ADDR: r_addr <= w_addr_next;
                    ST_LEN:  r_len  <= w_len_next;
                    ST_DATA: begin
                        r_word <= w_word_next;
                        if (w_word_done) begin
                            r_prog_we   <= N_TARGETS'(1) << r_cmd;
                            r_prog_addr <= r_addr;
                            r_prog_data <= w_word_next;
                            r_addr      <= r_addr + ADDR_W'(c_bpw);
                            r_len       <= r_len - 16'd1;
                        end
                    end
                    ST_CSUM: begin
                        if (w_rx_data != r_csum) begin
                            r_err_csum <= 1'b1;
                        end else if (r_cmd == CMD_HALT) begin
                            r_hold      <= 1'b1;
                            r_err_csum  <= 1'b0;
                            r_err_frame <= 1'b0;
                            r_err_cmd   <= 1'b0;
                        end else if ((r_cmd == CMD_RUN) &&
                                     !(r_err_csum || r_err_frame || r_err_cmd)) begin
                            r_hold <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign prog_addr = r_prog_addr;
    assign prog_data = r_prog_data;
    assign prog_we   = r_prog_we;
    assign cpu_hold  = r_hold;
    assign busy      = (r_state != ST_IDLE);
    assign err_csum  = r_err_csum;
    assign err_frame = r_err_frame;
    assign err_cmd   = r_err_cmd;

endmodule
`default_nettype wire

// File: doc/uart_loader.md
# uart_loader

Parametrised UART bootloader that receives framed, checksummed packets on a serial line and turns them into word writes into one of several target memories. It also holds the RISC-V core in reset while loading. It sits between the Bluetooth/UART pin and the CPU's programming ports (`prog_addr`/`prog_data`/`prog_we`), and its `cpu_hold` is combined into the CPU reset at top level. Over a single-memory loader it adds:
- configurable word width;
- multi-target writes;
- checksum and timeout error detection;
- explicit run/halt commands.

## Interface
- CLK_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: serial rate, 8N1, LSB first.
- ADDR_W, 32: programming address width.
- DATA_W, 32: word width, multiple of 8; BPW = DATA_W/8 bytes per word.
- N_TARGETS, 2: number of writable memories; target 0 = instruction memory.
- TIMEOUT_CYC, 5000000: idle cycles inside a frame before abort.
---
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- rx  in  1  asynchronous serial input, idle high.
- prog_addr  out  ADDR_W  byte address of current write.
- prog_data  out  DATA_W  write data.
- prog_we  out  N_TARGETS  one-hot write strobe, one-cycle pulse.
- cpu_hold  out  1  1 = CPU must be held in reset.
- busy  out  1  frame in progress (state != IDLE).
- err_csum, err_frame, err_cmd  out  1 each  sticky error flags.

## Operation
- Frame format: 0xA5 sync, CMD byte, then fields depending on CMD.
  - CMD < N_TARGETS (write): ADDR (ADDR_W/8 bytes, LE), LEN (2 bytes, LE, word count), LEN×BPW payload bytes (LE per word), CSUM.
  - CMD 0xFE (halt): CSUM.
  - CMD 0xFF (run): CSUM.
- CSUM = XOR of every byte from CMD through the last payload byte.
- FSM states: IDLE → CMD → ADDR → LEN → DATA → CSUM → IDLE. One byte counter is reused per field.
  - IDLE: bytes other than 0xA5 are ignored.
  - CMD: any value outside {0..N_TARGETS-1, 0xFE, 0xFF} sets err_cmd and returns to IDLE.
  - Halt/run skip directly to CSUM.
  - LEN = 0 skips DATA.
- Write frames:
  - cpu_hold rises when a valid write CMD is accepted.
  - Each completed word produces one prog_we[CMD] pulse; prog_addr then advances by BPW, wrapping modulo 2^ADDR_W.
  - Writes are not buffered. A bad CSUM sets err_csum, but the words are already written.
- Halt, with good CSUM: cpu_hold=1 and all error flags are cleared.
- Run, with good CSUM and all error flags clear: cpu_hold=0. With any flag set, run is ignored and hold stays asserted.
- Bad CSUM on halt or run: err_csum=1, no action taken.
- Timeout: TIMEOUT_CYC cycles without a received byte while state != IDLE sets err_frame and returns to IDLE. The partial word is dropped.
- Bad stop bit in the receiver: the byte is discarded, err_frame is set, and the FSM returns to IDLE.
- prog_addr and prog_data hold their last values between strobes.

## Timing
- Reset values: prog_addr=0, prog_data=0, prog_we=0, cpu_hold=0, busy=0, all error flags 0, state=IDLE.
- Reset mid-frame aborts immediately and drives all outputs to the reset values; nothing further is written.
- rx passes through a 2-flop synchronizer before use.
- Receiver timing:
  - Bit period = CLK_FREQ/BAUD_RATE cycles, integer division.
  - Data bits are sampled at mid-bit.
  - rx_valid pulses one cycle at mid-stop-bit.
- prog_we pulses on the cycle after the rx_valid of a word's last byte. prog_addr and prog_data are valid on that same cycle.
- cpu_hold and the error flags update on the cycle after the relevant rx_valid.
- A timeout and an rx_valid in the same cycle: the byte wins and the timeout counter clears.

## Structure
- Package `uart_loader_pkg`:
  - state enum;
  - constants SYNC_BYTE=8'hA5, CMD_HALT=8'hFE, CMD_RUN=8'hFF.
- Sub-module `uart_rx_8n1`:
  - parameters CLK_FREQ, BAUD_RATE;
  - ports clk, rst, rx, data[7:0], valid, frame_err.
- Word assembly (shift register, LE) and the FSM live in `uart_loader`.

## Test plan
1. Send A5 00 00 01 00 00 01 00 EF BE AD DE 22 → one pulse prog_we=2'b01 with prog_addr=0x100 and prog_data=0xDEADBEEF; cpu_hold=1; no errors.
2. Write frame with CMD=01, addr 0x0, LEN=3, payload 1,2,3 and correct CSUM → three prog_we=2'b10 pulses at addresses 0x0, 0x4, 0x8 with data 1, 2, 3.
3. Frame 1 with CSUM 0x23 → write still occurs and err_csum=1. A following run frame A5 FF FF leaves cpu_hold=1. Halt frame A5 FE FE clears err_csum, then A5 FF FF drops cpu_hold to 0.
4. A5 07 (bad CMD) → err_cmd=1, no prog_we; the following bytes are ignored until the next 0xA5.
5. A5 00 00 01 then silence > TIMEOUT_CYC (set to 1000 in the bench) → err_frame=1, busy=0, no prog_we.
6. Assert rst for one cycle in the middle of frame 1's payload → all outputs return to reset values; no prog_we pulse follows.
